id_operand_stage: RTL and testbench
===================================

// Module: id_operand_stage
// PURPOSE
//  Decode-stage stage register and operand unit between fetch and execute in the 5-stage pipeline.
//  Latches the fetched instruction fields and drives both regfile read ports.
//  Resolves EX/MEM RAW hazards by forwarding; the regfile covers WB via its write-through bypass.
//  Interlocks on load-use and hands operands to EX over a valid/allowin handshake.
// PARAMETERS
//  CTRL_W  16  width of opaque decoded-control bundle passed through to EX
// PORTS
//  clk             in   1       single clock; all state updates on posedge
//  resetn          in   1       synchronous, active-low reset
//  flush           in   1       kill instruction held in stage (branch redirect)
//  fs_valid        in   1       fetch presents an instruction
//  ds_allowin      out  1       stage accepts fs_* this cycle
//  fs_pc           in   32      instruction PC
//  fs_rs, fs_rt    in   5 each  source register indices
//  fs_use_rs/rt    in   1 each  instruction actually reads rs / rt
//  fs_dest         in   5       destination register; 0 = no write
//  fs_imm          in   32      extended immediate
//  fs_ctrl         in   CTRL_W  decoded control bundle
//  rf_raddr1/2     out  5 each  regfile read addresses (= held rs / rt)
//  rf_rdata1/2     in   32 each regfile read data (combinational)
//  es_valid        in   1       EX holds valid instruction
//  es_dest         in   5       EX destination
//  es_is_load      in   1       EX instruction is a load (result not ready)
//  es_result       in   32      EX ALU result
//  ms_valid        in   1       MEM holds valid instruction
//  ms_dest         in   5       MEM destination
//  ms_result       in   32      MEM final result (load data or ALU)
//  es_allowin      in   1       EX accepts this cycle
//  ds_to_es_valid  out  1       operands valid for EX
//  ds_pc/imm/ctrl/dest out 32/32/CTRL_W/5  held fields
//  ds_src1/src2    out  32 each forwarded operands
//  stall_cnt       out  32      load-use stall cycles counter
// BEHAVIOUR
//  - Reset (resetn=0 at posedge): ds_valid=0; all held fields=0; stall_cnt=0. Outputs follow.
//  - State: ds_valid bit + held fields; capture when fs_valid && ds_allowin (fields loaded, ds_valid=1).
//  - ds_allowin = !ds_valid || (ds_ready_go && es_allowin); ds_to_es_valid = ds_valid && ds_ready_go.
//  - Leaving without refill: ds_valid<=0 when ds_to_es_valid && es_allowin && !fs_valid.
//  - flush: ds_valid<=0 next cycle, overrides capture; fs_* that cycle discarded; ds_allowin unaffected.
//  - Operand select per source (src1 from rs, src2 from rt), priority high->low:
//      idx==0 -> 0; es_valid && es_dest==idx && !es_is_load -> es_result;
//      ms_valid && ms_dest==idx -> ms_result; else rf_rdata.
//  - Hazard: stall = ds_valid && es_valid && es_is_load && es_dest!=0 &&
//      ((use_rs && es_dest==rs) || (use_rt && es_dest==rt)); ds_ready_go = !stall.
//  - Unused source (use_*=0) never stalls; its operand still computed (don't-care to EX).
//  - EX match on load shadows MEM match for same idx (stall, never stale MEM value).
//  - stall_cnt +1 each cycle stall=1 (wraps at 2^32-1 -> 0); flush in a stall cycle still counts.
//  - Latency: fetch->EX handoff 1 cycle min; +1 per load-use stall cycle (typically 1).
//  - Held fields stable while ds_valid && !(ds_to_es_valid && es_allowin).
//  - Purely single-clock; no combinational path from fs_* to ds_* outputs.
// TESTING
//  1 Reset: resetn=0 2 cycles -> ds_to_es_valid=0, ds_allowin=1, stall_cnt=0, ds_src1=0.
//  2 EX fwd: rs=5, es_valid=1, es_dest=5, es_result=0x1234, rf_rdata1=0xDEAD -> ds_src1=0x1234.
//  3 Priority: rt=7, EX dest 7 result 0xA, MEM dest 7 result 0xB -> ds_src2=0xA; drop EX -> 0xB.
//  4 Load-use: lw dest 3 in EX, rs=3 use_rs=1 -> ds_to_es_valid=0, ds_allowin=0, stall_cnt+1; next cycle MEM fwd -> issues.
//  5 r0: rs=0, EX/MEM dest 0 result 0xFF -> ds_src1=0, no stall even if es_is_load.
//  6 Backpressure+flush: es_allowin=0 3 cycles -> fields stable; flush=1 -> ds_valid=0 next cycle, new fetch accepted.

Source files
------------

// File: rtl/id_operand_stage.sv
// Decode stage register and operand unit: it holds one fetched instruction, forwards EX/MEM
// results into both source operands, and interlocks on load-use before handing off to EX.
module id_operand_stage #(
  parameter int unsigned CTRL_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  // fetch side
  input  logic              fs_valid,
  output logic              ds_allowin,
  input  logic [31:0]       fs_pc,
  input  logic [4:0]        fs_rs,
  input  logic [4:0]        fs_rt,
  input  logic              fs_use_rs,
  input  logic              fs_use_rt,
  input  logic [4:0]        fs_dest,
  input  logic [31:0]       fs_imm,
  input  logic [CTRL_W-1:0] fs_ctrl,
  // regfile read ports
  output logic [4:0]        rf_raddr1,
  output logic [4:0]        rf_raddr2,
  input  logic [31:0]       rf_rdata1,
  input  logic [31:0]       rf_rdata2,
  // EX / MEM bypass sources
  input  logic              es_valid,
  input  logic [4:0]        es_dest,
  input  logic              es_is_load,
  input  logic [31:0]       es_result,
  input  logic              ms_valid,
  input  logic [4:0]        ms_dest,
  input  logic [31:0]       ms_result,
  // execute side
  input  logic              es_allowin,
  output logic              ds_to_es_valid,
  output logic [31:0]       ds_pc,
  output logic [31:0]       ds_imm,
  output logic [CTRL_W-1:0] ds_ctrl,
  output logic [4:0]        ds_dest,
  output logic [31:0]       ds_src1,
  output logic [31:0]       ds_src2,
  output logic [31:0]       stall_cnt
);

  logic              ds_valid_q, ds_valid_d;
  logic [31:0]       pc_q, pc_d;
  logic [4:0]        rs_q, rs_d;
  logic [4:0]        rt_q, rt_d;
  logic              use_rs_q, use_rs_d;
  logic              use_rt_q, use_rt_d;
  logic [4:0]        dest_q, dest_d;
  logic [31:0]       imm_q, imm_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;

  logic stall;
  logic ready_go;
  logic load_en;
  logic handoff;

  // An EX load matching idx is deliberately skipped here: that case stalls instead, so the
  // older MEM value for the same register must never be used.
  function automatic logic [31:0] fwd_operand(
    input logic [4:0]  idx,
    input logic [31:0] rf_data,
    input logic        ex_vld,
    input logic [4:0]  ex_dst,
    input logic        ex_ld,
    input logic [31:0] ex_res,
    input logic        mem_vld,
    input logic [4:0]  mem_dst,
    input logic [31:0] mem_res
  );
    logic [31:0] val;
    if (idx == 5'd0) begin
      val = 32'd0;
    end else if (ex_vld && (ex_dst == idx) && !ex_ld) begin
      val = ex_res;
    end else if (mem_vld && (mem_dst == idx)) begin
      val = mem_res;
    end else begin
      val = rf_data;
    end
    return val;
  endfunction

  // Load-use hazard detection and handshake.
  always_comb begin
    stall = ds_valid_q && es_valid && es_is_load && (es_dest != 5'd0) &&
            ((use_rs_q && (es_dest == rs_q)) || (use_rt_q && (es_dest == rt_q)));
    ready_go       = !stall;
    ds_allowin     = !ds_valid_q || (ready_go && es_allowin);
    ds_to_es_valid = ds_valid_q && ready_go;
    handoff        = ds_to_es_valid && es_allowin;
    load_en        = fs_valid && ds_allowin && !flush;
  end

  // Operand selection.
  always_comb begin
    rf_raddr1 = rs_q;
    rf_raddr2 = rt_q;
    ds_src1   = fwd_operand(rs_q, rf_rdata1, es_valid, es_dest, es_is_load, es_result,
                            ms_valid, ms_dest, ms_result);
    ds_src2   = fwd_operand(rt_q, rf_rdata2, es_valid, es_dest, es_is_load, es_result,
                            ms_valid, ms_dest, ms_result);
  end

  // Next-state for the stage register and the stall counter.
  always_comb begin
    ds_valid_d  = ds_valid_q;
    pc_d        = pc_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    use_rs_d    = use_rs_q;
    use_rt_d    = use_rt_q;
    dest_d      = dest_q;
    imm_d       = imm_q;
    ctrl_d      = ctrl_q;
    stall_cnt_d = stall_cnt_q;

    if (stall) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // Flush wins over both refill and departure; fetch data that cycle is dropped.
    if (flush) begin
      ds_valid_d = 1'b0;
    end else if (load_en) begin
      ds_valid_d = 1'b1;
      pc_d       = fs_pc;
      rs_d       = fs_rs;
      rt_d       = fs_rt;
      use_rs_d   = fs_use_rs;
      use_rt_d   = fs_use_rt;
      dest_d     = fs_dest;
      imm_d      = fs_imm;
      ctrl_d     = fs_ctrl;
    end else if (handoff) begin
      ds_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ds_valid_q  <= 1'b0;
      pc_q        <= 32'd0;
      rs_q        <= 5'd0;
      rt_q        <= 5'd0;
      use_rs_q    <= 1'b0;
      use_rt_q    <= 1'b0;
      dest_q      <= 5'd0;
      imm_q       <= 32'd0;
      ctrl_q      <= '0;
      stall_cnt_q <= 32'd0;
    end else begin
      ds_valid_q  <= ds_valid_d;
      pc_q        <= pc_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      use_rs_q    <= use_rs_d;
      use_rt_q    <= use_rt_d;
      dest_q      <= dest_d;
      imm_q       <= imm_d;
      ctrl_q      <= ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ds_pc     = pc_q;
  assign ds_imm    = imm_q;
  assign ds_ctrl   = ctrl_q;
  assign ds_dest   = dest_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Bench for id_operand_stage: directed literal checks followed by randomized traffic compared
// every cycle against a queue-based model of the single instruction slot.
module tb_id_operand_stage;

  logic        clk = 1'b0;
  logic        resetn, flush, fs_valid, ds_allowin;
  logic [31:0] fs_pc, fs_imm;
  logic [4:0]  fs_rs, fs_rt, fs_dest;
  logic        fs_use_rs, fs_use_rt;
  logic [15:0] fs_ctrl;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        es_valid, es_is_load, ms_valid, es_allowin;
  logic [4:0]  es_dest, ms_dest;
  logic [31:0] es_result, ms_result;
  logic        ds_to_es_valid;
  logic [31:0] ds_pc, ds_imm, ds_src1, ds_src2, stall_cnt;
  logic [15:0] ds_ctrl;
  logic [4:0]  ds_dest;

  always #5 clk = ~clk;

  id_operand_stage #(.CTRL_W(16)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .fs_valid(fs_valid), .ds_allowin(ds_allowin),
    .fs_pc(fs_pc), .fs_rs(fs_rs), .fs_rt(fs_rt), .fs_use_rs(fs_use_rs), .fs_use_rt(fs_use_rt),
    .fs_dest(fs_dest), .fs_imm(fs_imm), .fs_ctrl(fs_ctrl), .rf_raddr1(rf_raddr1),
    .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .es_valid(es_valid),
    .es_dest(es_dest), .es_is_load(es_is_load), .es_result(es_result), .ms_valid(ms_valid),
    .ms_dest(ms_dest), .ms_result(ms_result), .es_allowin(es_allowin),
    .ds_to_es_valid(ds_to_es_valid), .ds_pc(ds_pc), .ds_imm(ds_imm), .ds_ctrl(ds_ctrl),
    .ds_dest(ds_dest), .ds_src1(ds_src1), .ds_src2(ds_src2), .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        use_rs;
    logic        use_rt;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic [15:0] ctrl;
  } instr_t;

  instr_t      slot_q[$];  // instructions accepted but not yet handed to EX (0 or 1)
  logic [31:0] m_cnt;
  int          checks = 0;
  int          passes = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [31:0] exp_operand(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 0) return 32'd0;
    if (es_valid && es_dest == idx && !es_is_load) return es_result;
    if (ms_valid && ms_dest == idx) return ms_result;
    return rf;
  endfunction

  function automatic logic model_stall();
    instr_t h;
    if (slot_q.size() == 0) return 1'b0;
    h = slot_q[0];
    return es_valid && es_is_load && es_dest != 0 &&
           ((h.use_rs && es_dest == h.rs) || (h.use_rt && es_dest == h.rt));
  endfunction

  task automatic model_compare();
    logic   occ, stl, go;
    instr_t h;
    occ = slot_q.size() != 0;
    stl = model_stall();
    go  = occ && !stl;
    chk("allowin", {31'd0, ds_allowin}, {31'd0, !occ || (!stl && es_allowin)});
    chk("to_es_valid", {31'd0, ds_to_es_valid}, {31'd0, go});
    chk("stall_cnt", stall_cnt, m_cnt);
    if (occ) begin
      h = slot_q[0];
      chk("raddr1", {27'd0, rf_raddr1}, {27'd0, h.rs});
      chk("raddr2", {27'd0, rf_raddr2}, {27'd0, h.rt});
      chk("src1", ds_src1, exp_operand(h.rs, rf_rdata1));
      chk("src2", ds_src2, exp_operand(h.rt, rf_rdata2));
    end
    if (go) begin
      chk("pc", ds_pc, h.pc);
      chk("imm", ds_imm, h.imm);
      chk("ctrl", {16'd0, ds_ctrl}, {16'd0, h.ctrl});
      chk("dest", {27'd0, ds_dest}, {27'd0, h.dest});
    end
  endtask

  task automatic model_update();
    logic   occ, stl, allow;
    instr_t n;
    if (!resetn) begin
      slot_q.delete();
      m_cnt = 32'd0;
      return;
    end
    occ   = slot_q.size() != 0;
    stl   = model_stall();
    allow = !occ || (!stl && es_allowin);
    if (stl) m_cnt = m_cnt + 32'd1;
    if (occ && !stl && es_allowin) void'(slot_q.pop_front());
    if (flush) begin
      slot_q.delete();
    end else if (fs_valid && allow) begin
      n = '{pc: fs_pc, rs: fs_rs, rt: fs_rt, use_rs: fs_use_rs, use_rt: fs_use_rt,
            dest: fs_dest, imm: fs_imm, ctrl: fs_ctrl};
      slot_q.push_back(n);
    end
  endtask

  // Inputs are set at negedge and settled by the caller; compare, clock, return at negedge.
  task automatic tick();
    model_compare();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic fetch(input logic v, input logic [31:0] pc, input logic [4:0] rs,
                       input logic urs, input logic [4:0] rt, input logic urt,
                       input logic [4:0] dest);
    fs_valid = v; fs_pc = pc; fs_rs = rs; fs_use_rs = urs; fs_rt = rt; fs_use_rt = urt;
    fs_dest = dest; fs_imm = pc + 32'h10; fs_ctrl = pc[15:0] ^ 16'h5a5a;
  endtask

  initial begin
    resetn = 0; flush = 0; es_allowin = 0;
    fetch(0, 0, 0, 0, 0, 0, 0);
    rf_rdata1 = 32'hDEAD; rf_rdata2 = 32'hBEEF;
    es_valid = 0; es_dest = 0; es_is_load = 0; es_result = 0;
    ms_valid = 0; ms_dest = 0; ms_result = 0;
    slot_q.delete(); m_cnt = 0;
    @(negedge clk);
    @(posedge clk); model_update(); @(negedge clk);
    @(posedge clk); model_update(); @(negedge clk);
    #1;
    // Reset state
    chk("rst_to_es", {31'd0, ds_to_es_valid}, 32'd0);
    chk("rst_allowin", {31'd0, ds_allowin}, 32'd1);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_src1", ds_src1, 32'd0);
    resetn = 1;
    #1 tick();

    // EX forwarding on rs
    fetch(1, 32'h100, 5, 1, 0, 0, 9);
    #1 tick();
    fetch(0, 0, 0, 0, 0, 0, 0);
    es_valid = 1; es_dest = 5; es_result = 32'h1234;
    #1;
    chk("ex_fwd_src1", ds_src1, 32'h1234);
    chk("ex_fwd_pc", ds_pc, 32'h100);
    tick();

    // EX over MEM priority on rt
    es_allowin = 1;
    fetch(1, 32'h180, 0, 0, 7, 1, 2);
    #1 tick();
    es_allowin = 0;
    fetch(0, 0, 0, 0, 0, 0, 0);
    es_dest = 7; es_result = 32'hA; ms_valid = 1; ms_dest = 7; ms_result = 32'hB;
    rf_rdata2 = 32'hCC;
    #1 chk("prio_ex", ds_src2, 32'hA);
    es_valid = 0;
    #1 chk("prio_mem", ds_src2, 32'hB);
    // r0 never forwarded and never stalls
    es_valid = 1; es_dest = 0; es_is_load = 1; es_result = 32'hFF;
    ms_dest = 0; ms_result = 32'hFF;
    #1;
    chk("r0_src1", ds_src1, 32'd0);
    chk("r0_no_stall", {31'd0, ds_to_es_valid}, 32'd1);
    tick();

    // Load-use stall then MEM forward
    es_allowin = 1; es_valid = 0; es_is_load = 0; ms_valid = 0;
    fetch(1, 32'h200, 3, 1, 0, 0, 4);
    #1 tick();
    fetch(0, 0, 0, 0, 0, 0, 0);
    es_valid = 1; es_dest = 3; es_is_load = 1;
    #1;
    chk("lu_to_es", {31'd0, ds_to_es_valid}, 32'd0);
    chk("lu_allowin", {31'd0, ds_allowin}, 32'd0);
    tick();
    es_valid = 0; es_is_load = 0; ms_valid = 1; ms_dest = 3; ms_result = 32'h77;
    #1;
    chk("lu_cnt", stall_cnt, 32'd1);
    chk("lu_issue", {31'd0, ds_to_es_valid}, 32'd1);
    chk("lu_src1", ds_src1, 32'h77);
    tick();
    ms_valid = 0;
    #1 chk("lu_drained", {31'd0, ds_to_es_valid}, 32'd0);

    // Backpressure holds fields; flush empties the stage
    es_allowin = 0;
    fetch(1, 32'h300, 1, 1, 2, 1, 6);
    #1 tick();
    fetch(1, 32'h999, 8, 1, 8, 1, 8);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_pc", ds_pc, 32'h300);
      tick();
    end
    flush = 1;
    fetch(1, 32'h400, 1, 0, 1, 0, 1);
    #1 tick();
    flush = 0;
    fetch(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("fl_to_es", {31'd0, ds_to_es_valid}, 32'd0);
    chk("fl_allowin", {31'd0, ds_allowin}, 32'd1);
    fetch(1, 32'h500, 4, 1, 5, 1, 6);
    #1 tick();
    fetch(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("fl_refill_pc", ds_pc, 32'h500);
    chk("fl_refill_vld", {31'd0, ds_to_es_valid}, 32'd1);
    tick();

    // Randomized traffic with small register indices so hazards are frequent
    for (int c = 0; c < 4000; c++) begin
      resetn     = ($urandom_range(0, 199) != 0);
      flush      = ($urandom_range(0, 9) == 0);
      es_allowin = ($urandom_range(0, 3) != 0);
      fetch($urandom_range(0, 2) != 0, $urandom, 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)));
      fs_imm     = $urandom;
      fs_ctrl    = 16'($urandom);
      rf_rdata1  = $urandom;
      rf_rdata2  = $urandom;
      es_valid   = 1'($urandom_range(0, 1));
      es_dest    = 5'($urandom_range(0, 7));
      es_is_load = ($urandom_range(0, 2) == 0);
      es_result  = $urandom;
      ms_valid   = 1'($urandom_range(0, 1));
      ms_dest    = 5'($urandom_range(0, 7));
      ms_result  = $urandom;
      #1 tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
